input_mem: RTL and testbench

Read-side counterpart of the output packer in the rotate datapath. Accepts 32-bit AHB read-data words from the fetch side, unpacks each word into four bytes in a 64-byte pixel buffer, and serves three independent byte read ports (B, G, R) to the rotate engine. Byte order matches the write-side packer: byte 4w+0 occupies bits [31:24] of word w. A small fill state machine tracks buffer occupancy and flags overflow.

---
 rtl/input_mem.sv | 145 ++++++++++++++
 tb/tb_input_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_mem.sv
`default_nettype none
// ============================================================================
//  Module   : input_mem
//  Purpose  : Unpacks 32-bit AHB read words into a byte pixel buffer and
//             serves three independent registered byte read ports (B/G/R).
//  Revision : 1.0  initial release
// ============================================================================
module input_mem #(
    parameter int MEM_BYTES = 64,
    parameter int WORDS     = MEM_BYTES / 4
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic        I_START,
    input  logic [31:0] I_RDATA,
    input  logic        I_RVALID,
    input  logic [7:0]  I_PIXEL_IN_ADDRB,
    input  logic [7:0]  I_PIXEL_IN_ADDRG,
    input  logic [7:0]  I_PIXEL_IN_ADDRR,
    output logic [7:0]  O_PIXEL_B,
    output logic [7:0]  O_PIXEL_G,
    output logic [7:0]  O_PIXEL_R,
    output logic [4:0]  O_WORD_CNT,
    output logic        O_FULL,
    output logic        O_BUSY,
    output logic        O_OVERFLOW
);

    localparam int                 c_ADDR_W    = $clog2(MEM_BYTES);
    localparam int                 c_PTR_W     = $clog2(WORDS);
    localparam logic [8:0]         c_MEM_LIMIT = 9'(MEM_BYTES);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(WORDS - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [4:0]           r_word_cnt;
    logic                 r_overflow;
    logic [7:0]           r_mem [MEM_BYTES];
    logic                 w_wr;

    // Start takes priority over a coincident valid word, which is dropped.
    assign w_wr = (r_state == ST_FILL) && I_RVALID && !I_START;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (I_START) begin
            w_next_state = ST_FILL;
        end else if (w_wr && (r_ptr == c_LAST_PTR)) begin
            w_next_state = ST_FULL;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_ptr      <= '0;
            r_word_cnt <= 5'd0;
            r_overflow <= 1'b0;
        end else if (I_START) begin
            r_ptr      <= '0;
            r_word_cnt <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_ptr      <= r_ptr + c_PTR_ONE;
                r_word_cnt <= r_word_cnt + 5'd1;
            end
            if ((r_state == ST_FULL) && I_RVALID) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Byte 4p+0 takes the most significant byte of the word.
    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                r_mem[{r_ptr, 2'(b)}] <= I_RDATA[8*(3-b) +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        logic [7:0] w_addr;
        logic [7:0] w_rd;
        logic [7:0] r_pix;

        assign w_addr = (gi == 0) ? I_PIXEL_IN_ADDRB :
                        (gi == 1) ? I_PIXEL_IN_ADDRG : I_PIXEL_IN_ADDRR;

        // Bypass returns the byte being written this cycle instead of stale memory.
        always_comb begin
            w_rd = 8'h00;
            if ({1'b0, w_addr} < c_MEM_LIMIT) begin
                if (w_wr && (w_addr[c_ADDR_W-1:2] == r_ptr)) begin
                    case (w_addr[1:0])
                        2'd0:    w_rd = I_RDATA[31:24];
                        2'd1:    w_rd = I_RDATA[23:16];
                        2'd2:    w_rd = I_RDATA[15:8];
                        default: w_rd = I_RDATA[7:0];
                    endcase
                end else begin
                    w_rd = r_mem[w_addr[c_ADDR_W-1:0]];
                end
            end
        end

        always_ff @(posedge I_HCLK) begin
            if (I_HRESET) begin
                r_pix <= 8'h00;
            end else begin
                r_pix <= w_rd;
            end
        end
    end

    assign O_PIXEL_B  = g_port[0].r_pix;
    assign O_PIXEL_G  = g_port[1].r_pix;
    assign O_PIXEL_R  = g_port[2].r_pix;
    assign O_WORD_CNT = r_word_cnt;
    assign O_FULL     = (r_state == ST_FULL);
    assign O_BUSY     = (r_state == ST_FILL);
    assign O_OVERFLOW = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_input_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_mem
//  Purpose  : Directed scoreboard bench for input_mem.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  addr_b, addr_g, addr_r;
    logic [7:0]  pix_b, pix_g, pix_r;
    logic [4:0]  word_cnt;
    logic        full, busy, ovf;

    localparam int SEL_B = 0, SEL_G = 1, SEL_R = 2, SEL_CNT = 3,
                   SEL_FULL = 4, SEL_BUSY = 5, SEL_OVF = 6;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    input_mem dut (
        .I_HCLK           (clk),
        .I_HRESET         (rst),
        .I_START          (start),
        .I_RDATA          (rdata),
        .I_RVALID         (rvalid),
        .I_PIXEL_IN_ADDRB (addr_b),
        .I_PIXEL_IN_ADDRG (addr_g),
        .I_PIXEL_IN_ADDRR (addr_r),
        .O_PIXEL_B        (pix_b),
        .O_PIXEL_G        (pix_g),
        .O_PIXEL_R        (pix_r),
        .O_WORD_CNT       (word_cnt),
        .O_FULL           (full),
        .O_BUSY           (busy),
        .O_OVERFLOW       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            SEL_B:    return pix_b;
            SEL_G:    return pix_g;
            SEL_R:    return pix_r;
            SEL_CNT:  return {3'b000, word_cnt};
            SEL_FULL: return {7'd0, full};
            SEL_BUSY: return {7'd0, busy};
            default:  return {7'd0, ovf};
        endcase
    endfunction

    // Monitor: outputs settle after the rising edge; compare on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            n_checks++;
            if (e.cyc != cyc || a !== e.val) begin
                n_errors++;
                $display("FAIL %s cyc=%0d: got %02h expected %02h", e.name, cyc, a, e.val);
            end
        end
    end

    // Expectation for the edge that samples the inputs currently driven.
    task automatic expect_out(input int sel, input logic [7:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        addr_b = b;
        addr_g = g;
        addr_r = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        set_addr(8'd0, 8'd1, 8'd2);
        expect_out(SEL_B, 8'h00, "rst_b");
        expect_out(SEL_G, 8'h00, "rst_g");
        expect_out(SEL_R, 8'h00, "rst_r");
        expect_out(SEL_CNT, 8'd0, "rst_cnt");
        expect_out(SEL_FULL, 8'd0, "rst_full");
        expect_out(SEL_BUSY, 8'd0, "rst_busy");
        expect_out(SEL_OVF, 8'd0, "rst_ovf");
        tick();
        tick();

        // Idle: valid data must be ignored.
        rst = 1'b0;
        expect_out(SEL_CNT, 8'd0, "idle_cnt");
        expect_out(SEL_BUSY, 8'd0, "idle_busy");
        expect_out(SEL_B, 8'h00, "idle_b");
        tick();

        start = 1'b1; rvalid = 1'b0;
        expect_out(SEL_BUSY, 8'd1, "start_busy");
        expect_out(SEL_CNT, 8'd0, "start_cnt");
        tick();
        start = 1'b0;

        for (int w = 0; w < 16; w++) begin
            rvalid = 1'b1;
            rdata  = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            if (w == 2) begin
                rdata = 32'hA1B2_C3D4;
                set_addr(8'd8, 8'd9, 8'd11);
                expect_out(SEL_B, 8'hA1, "bypass_b");
                expect_out(SEL_G, 8'hB2, "bypass_g");
                expect_out(SEL_R, 8'hD4, "bypass_r");
            end
            if (w == 3) begin
                expect_out(SEL_B, 8'hA1, "stored_b");
                expect_out(SEL_G, 8'hB2, "stored_g");
                expect_out(SEL_R, 8'hD4, "stored_r");
            end
            expect_out(SEL_CNT, 8'(w + 1), "fill_cnt");
            expect_out(SEL_FULL, (w == 15) ? 8'd1 : 8'd0, "fill_full");
            expect_out(SEL_BUSY, (w == 15) ? 8'd0 : 8'd1, "fill_busy");
            tick();
        end

        rvalid = 1'b0;
        set_addr(8'd0, 8'd37, 8'd63);
        expect_out(SEL_B, 8'h00, "read0");
        expect_out(SEL_G, 8'h25, "read37");
        expect_out(SEL_R, 8'h3F, "read63");
        tick();

        // 17th word: rejected, flagged.
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        expect_out(SEL_OVF, 8'd1, "ovf_set");
        expect_out(SEL_CNT, 8'd16, "ovf_cnt");
        expect_out(SEL_FULL, 8'd1, "ovf_full");
        expect_out(SEL_B, 8'h00, "ovf_nobypass");
        tick();
        rvalid = 1'b0;
        expect_out(SEL_B, 8'h00, "ovf_byte0");
        expect_out(SEL_OVF, 8'd1, "ovf_sticky");
        tick();

        // Start with coincident valid: word dropped.
        start = 1'b1; rvalid = 1'b1; rdata = 32'h1122_3344;
        expect_out(SEL_OVF, 8'd0, "coll_ovf");
        expect_out(SEL_CNT, 8'd0, "coll_cnt");
        expect_out(SEL_BUSY, 8'd1, "coll_busy");
        expect_out(SEL_FULL, 8'd0, "coll_full");
        expect_out(SEL_B, 8'h00, "coll_b");
        tick();
        start = 1'b0; rdata = 32'h5566_7788;
        set_addr(8'd0, 8'd1, 8'd3);
        expect_out(SEL_CNT, 8'd1, "next_cnt");
        expect_out(SEL_B, 8'h55, "next_b");
        expect_out(SEL_G, 8'h66, "next_g");
        expect_out(SEL_R, 8'h88, "next_r");
        tick();
        rvalid = 1'b0;
        expect_out(SEL_B, 8'h55, "next_mem_b");
        expect_out(SEL_G, 8'h66, "next_mem_g");
        expect_out(SEL_R, 8'h88, "next_mem_r");
        tick();

        set_addr(8'h40, 8'hFF, 8'h3F);
        expect_out(SEL_B, 8'h00, "oor_40");
        expect_out(SEL_G, 8'h00, "oor_ff");
        expect_out(SEL_R, 8'h3F, "inrange_3f");
        tick();

        // Four more words (five total), then a mid-fill reset.
        for (int w = 1; w < 5; w++) begin
            rvalid = 1'b1; rdata = 32'hA5A5_A5A5;
            expect_out(SEL_CNT, 8'(w + 1), "mid_cnt");
            tick();
        end
        rvalid = 1'b0; rst = 1'b1;
        expect_out(SEL_CNT, 8'd0, "mrst_cnt");
        expect_out(SEL_BUSY, 8'd0, "mrst_busy");
        tick();
        rst = 1'b0;

        // Post-reset: idle ignores valid; memory reads back cleared.
        for (int a = 0; a < 20; a++) begin
            rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
            set_addr(8'(a), 8'(a), 8'(a));
            expect_out(SEL_B, 8'h00, "clr_b");
            expect_out(SEL_G, 8'h00, "clr_g");
            expect_out(SEL_R, 8'h00, "clr_r");
            expect_out(SEL_CNT, 8'd0, "clr_cnt");
            tick();
        end
        rvalid = 1'b0;

        repeat (3) tick();
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pending: %0d expectations never checked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
